// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer
//
// Write-side packer for the asynchronous FIFO, in the wr_clk domain.
// Narrow IN_WIDTH-bit beats arrive on a valid/ready stream and are packed
// LSB-first into DATA_WIDTH-bit words. A completed word sits in a one-word
// holding register until the FIFO can take it. A beat flagged in_last closes
// the current word early; the unused upper lanes are zero-padded.
//
// Ports:
//   wr_clk         in   write-domain clock
//   wr_rst         in   asynchronous active-high reset
//   in_valid       in   upstream beat valid
//   in_data        in   upstream beat (IN_WIDTH)
//   in_last        in   last beat of a frame, flush the word after it
//   in_ready       out  beat accepted when in_valid && in_ready
//   fifo_wr_en     out  FIFO write enable
//   fifo_wr_data   out  FIFO write data (DATA_WIDTH)
//   fifo_wr_full   in   FIFO full flag
//   partial_flush  out  one-cycle pulse after a zero-padded word was formed
//   word_count     out  saturating count of words written (CNT_WIDTH)
//
// DATA_WIDTH must be an integer multiple of IN_WIDTH, ratio at least 2.

module fifo_wr_packer #(
   parameter int IN_WIDTH   = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  wr_clk,
   input  logic                  wr_rst,
   input  logic                  in_valid,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_wr_data,
   input  logic                  fifo_wr_full,
   output logic                  partial_flush,
   output logic [CNT_WIDTH-1:0]  word_count
);

   localparam int R     = DATA_WIDTH / IN_WIDTH;
   localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);

   logic [DATA_WIDTH-1:0] acc_reg;
   logic [IDX_W-1:0]      idx_reg;
   logic [DATA_WIDTH-1:0] out_reg;
   logic                  out_pend_reg;
   logic                  partial_flush_reg;
   logic [CNT_WIDTH-1:0]  word_count_reg;

   logic                  accept;
   logic                  at_last_lane;
   logic                  word_done;
   logic [DATA_WIDTH-1:0] acc_merged;   // accumulator with the current beat written in
   logic [DATA_WIDTH-1:0] word_next;    // acc_merged with lanes above idx cleared

   // The holding register blocks new beats only while it cannot drain this
   // cycle; when it drains, a beat that completes a word may reload it.
   assign in_ready     = !(out_pend_reg && fifo_wr_full) && !wr_rst;
   assign fifo_wr_en   = out_pend_reg && !fifo_wr_full;
   assign fifo_wr_data = out_reg;
   assign partial_flush = partial_flush_reg;
   assign word_count   = word_count_reg;

   assign accept       = in_valid && in_ready;
   assign at_last_lane = (idx_reg == LAST_IDX);
   assign word_done    = accept && (at_last_lane || in_last);

   genvar gi;
   generate
      for (gi = 0; gi < R; gi++) begin : g_lane
         localparam logic [IDX_W-1:0] LANE = IDX_W'(gi);
         assign acc_merged[gi*IN_WIDTH +: IN_WIDTH] =
            (idx_reg == LANE) ? in_data : acc_reg[gi*IN_WIDTH +: IN_WIDTH];
         // Lanes above the current one stay zero so an early flush is padded.
         assign word_next[gi*IN_WIDTH +: IN_WIDTH] =
            (LANE > idx_reg) ? '0 : acc_merged[gi*IN_WIDTH +: IN_WIDTH];
      end
   endgenerate

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         acc_reg           <= '0;
         idx_reg           <= '0;
         out_reg           <= '0;
         out_pend_reg      <= 1'b0;
         partial_flush_reg <= 1'b0;
         word_count_reg    <= '0;
      end else begin
         if (accept) begin
            if (word_done) begin
               out_reg <= word_next;
               acc_reg <= '0;
               idx_reg <= '0;
            end else begin
               acc_reg <= acc_merged;
               idx_reg <= idx_reg + IDX_W'(1);
            end
         end

         // A reload on the draining edge keeps the register occupied.
         if (word_done)
            out_pend_reg <= 1'b1;
         else if (fifo_wr_en)
            out_pend_reg <= 1'b0;

         partial_flush_reg <= accept && in_last && !at_last_lane;

         if (fifo_wr_en && (word_count_reg != {CNT_WIDTH{1'b1}}))
            word_count_reg <= word_count_reg + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer
//
// Directed testbench for fifo_wr_packer (IN_WIDTH=4, DATA_WIDTH=8,
// CNT_WIDTH=4). A frame-level model tracks accepted beats, the words they
// form and the words still waiting for the FIFO; a compare process checks the
// DUT outputs against it every cycle, and literal checks pin key values.

module tb_fifo_wr_packer;

   localparam int IN_W  = 4;
   localparam int DW    = 8;
   localparam int CW    = 4;
   localparam int R     = DW / IN_W;
   localparam int CMAX  = (1 << CW) - 1;

   logic            wr_clk;
   logic            wr_rst;
   logic            in_valid;
   logic [IN_W-1:0] in_data;
   logic            in_last;
   logic            in_ready;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wr_data;
   logic            fifo_wr_full;
   logic            partial_flush;
   logic [CW-1:0]   word_count;

   int n_checks = 0;
   int n_pass   = 0;

   fifo_wr_packer #(
      .IN_WIDTH   (IN_W),
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .wr_clk        (wr_clk),
      .wr_rst        (wr_rst),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_wr_data  (fifo_wr_data),
      .fifo_wr_full  (fifo_wr_full),
      .partial_flush (partial_flush),
      .word_count    (word_count)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int          beats[$];     // beats accepted into the word being built
   logic [31:0] words[$];     // formed words not yet taken by the FIFO
   bit          pf_exp;
   int          cnt_exp;

   always @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         beats.delete();
         words.delete();
         pf_exp  = 0;
         cnt_exp = 0;
      end else begin
         bit          held;
         bit          take;
         bit          wrote;
         logic [31:0] w;
         held  = (words.size() > 0);
         take  = in_valid && !(held && fifo_wr_full);
         wrote = held && !fifo_wr_full;
         pf_exp = 0;
         if (wrote) begin
            void'(words.pop_front());
            if (cnt_exp < CMAX) cnt_exp++;
         end
         if (take) begin
            beats.push_back(int'(in_data));
            if (beats.size() == R || in_last) begin
               w = 0;
               foreach (beats[i]) w += beats[i] * (1 << (IN_W * i));
               words.push_back(w);
               pf_exp = (beats.size() < R);
               beats.delete();
            end
         end
      end
   end

   always @(negedge wr_clk) begin
      if (wr_rst) begin
         chk("rst_ready", in_ready, 0);
         chk("rst_wr_en", fifo_wr_en, 0);
         chk("rst_wr_data", fifo_wr_data, 0);
         chk("rst_pflush", partial_flush, 0);
         chk("rst_count", word_count, 0);
      end else begin
         bit held;
         held = (words.size() > 0);
         chk("model_ready", in_ready, !(held && fifo_wr_full));
         chk("model_wr_en", fifo_wr_en, held && !fifo_wr_full);
         if (held) chk("model_wr_data", fifo_wr_data, words[0]);
         chk("model_pflush", partial_flush, pf_exp);
         chk("model_count", word_count, cnt_exp);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called and returning at posedge+1; presents one beat until accepted.
   task automatic send(input logic [IN_W-1:0] d, input logic l);
      int k;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      k = 0;
      @(negedge wr_clk);
      while (!in_ready && k < 200) begin
         @(negedge wr_clk);
         k++;
      end
      if (k >= 200) chk("send_timeout_ready", in_ready, 1);
      @(posedge wr_clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge wr_clk);
      #1;
      wr_rst   = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      fifo_wr_full = 1'b0;
      repeat (2) @(posedge wr_clk);
      #1;
      wr_rst = 1'b0;
   endtask

   task automatic step();
      @(posedge wr_clk);
      #1;
   endtask

   initial begin
      wr_rst       = 1'b1;
      in_valid     = 1'b0;
      in_data      = '0;
      in_last      = 1'b0;
      fifo_wr_full = 1'b0;
      repeat (2) @(posedge wr_clk);
      #1;
      wr_rst = 1'b0;

      // 1. basic pack
      send(4'h3, 1'b0);
      send(4'hA, 1'b0);
      @(negedge wr_clk);
      chk("t1_wr_en", fifo_wr_en, 1);
      chk("t1_data", fifo_wr_data, 8'hA3);
      chk("t1_pflush", partial_flush, 0);
      step();
      @(negedge wr_clk);
      chk("t1_count", word_count, 1);
      chk("t1_wr_en_after", fifo_wr_en, 0);

      // 2. partial flush
      do_reset();
      send(4'h5, 1'b1);
      @(negedge wr_clk);
      chk("t2_data", fifo_wr_data, 8'h05);
      chk("t2_pflush", partial_flush, 1);
      step();
      @(negedge wr_clk);
      chk("t2_pflush_once", partial_flush, 0);
      step();
      send(4'h6, 1'b0);
      send(4'h7, 1'b0);
      @(negedge wr_clk);
      chk("t2_lane0_again", fifo_wr_data, 8'h76);

      // 3. full stall
      do_reset();
      fifo_wr_full = 1'b1;
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      in_valid = 1'b1;
      in_data  = 4'h3;
      repeat (3) begin
         @(negedge wr_clk);
         chk("t3_stall_ready", in_ready, 0);
         chk("t3_stall_wr_en", fifo_wr_en, 0);
         chk("t3_held_data", fifo_wr_data, 8'h21);
         step();
      end
      fifo_wr_full = 1'b0;
      @(negedge wr_clk);
      chk("t3_release_wr_en", fifo_wr_en, 1);
      chk("t3_release_ready", in_ready, 1);
      step();
      in_data = 4'h4;
      @(negedge wr_clk);
      step();
      in_valid = 1'b0;
      @(negedge wr_clk);
      chk("t3_second_data", fifo_wr_data, 8'h43);
      step();
      @(negedge wr_clk);
      chk("t3_count", word_count, 2);

      // 4. drain and reload in the same cycle
      do_reset();
      fifo_wr_full = 1'b1;
      send(4'h5, 1'b1);
      in_valid = 1'b1;
      in_data  = 4'h9;
      in_last  = 1'b1;
      repeat (2) begin
         @(negedge wr_clk);
         chk("t4_blocked", in_ready, 0);
         step();
      end
      fifo_wr_full = 1'b0;
      @(negedge wr_clk);
      chk("t4_first_data", fifo_wr_data, 8'h05);
      chk("t4_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge wr_clk);
      chk("t4_second_en", fifo_wr_en, 1);
      chk("t4_second_data", fifo_wr_data, 8'h09);
      step();
      @(negedge wr_clk);
      chk("t4_count", word_count, 2);
      chk("t4_idle_en", fifo_wr_en, 0);

      // 5a. reset mid-word
      do_reset();
      send(4'h7, 1'b0);
      wr_rst = 1'b1;
      @(negedge wr_clk);
      chk("t5_ready_in_rst", in_ready, 0);
      step();
      wr_rst = 1'b0;
      send(4'hB, 1'b0);
      send(4'hC, 1'b0);
      @(negedge wr_clk);
      chk("t5_fresh_word", fifo_wr_data, 8'hCB);
      step();

      // 5b. reset while a word is held
      do_reset();
      fifo_wr_full = 1'b1;
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      @(negedge wr_clk);
      chk("t5_held", fifo_wr_data, 8'h21);
      step();
      wr_rst = 1'b1;
      @(negedge wr_clk);
      chk("t5_rst_data", fifo_wr_data, 0);
      step();
      fifo_wr_full = 1'b0;
      @(negedge wr_clk);
      chk("t5_rst_wr_en", fifo_wr_en, 0);
      step();
      wr_rst = 1'b0;
      @(negedge wr_clk);
      chk("t5_no_stale_write", fifo_wr_en, 0);
      chk("t5_ready_after", in_ready, 1);
      step();

      // 6. counter saturation: 20 words
      do_reset();
      for (int i = 0; i < 2 * 20; i++) begin
         logic [31:0] v;
         v = i;
         send(v[IN_W-1:0], 1'b0);
      end
      repeat (3) step();
      @(negedge wr_clk);
      chk("t6_saturated", word_count, 15);

      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
